// File: rtl/bram_frame_reader_pkg.sv
// Shared types and defaults for the frame BRAM read master.
package bram_frame_reader_pkg;

    // Read master control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DEF_ADDR_WIDTH = 18;
    localparam int DEF_BIT_WIDTH  = 8;
    localparam int DEF_IMG_WIDTH  = 512;
    localparam int DEF_IMG_HEIGHT = 512;

    // Counter width for a dimension; never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bram_frame_reader_pix_fifo2.sv
// Two-entry pixel FIFO that absorbs the BRAM read latency in front of the stream port.
module pix_fifo2
    import bram_frame_reader_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [BIT_WIDTH-1:0] din,
    input  logic                 pop,
    output logic [BIT_WIDTH-1:0] dout,
    output logic                 full,
    output logic                 empty,
    output logic [1:0]           count
);

    logic [BIT_WIDTH-1:0] mem_p1 [2];
    logic                 wr_ptr;
    logic                 rd_ptr;

    assign dout  = mem_p1[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

    // Pointers and occupancy; push and pop may coincide at any fill level
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the empty flag qualifies it
    always_ff @(posedge clk) begin
        if (push) mem_p1[wr_ptr] <= din;
    end

    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && !pop && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/bram_frame_reader.sv
// Raster-order frame reader: sweeps the frame BRAM and streams pixels with line/frame sidebands.
module bram_frame_reader
    import bram_frame_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  bram_ena,
    output logic                  bram_wea,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    output logic [BIT_WIDTH-1:0]  bram_dina,
    input  logic [BIT_WIDTH-1:0]  bram_douta,
    output logic [BIT_WIDTH-1:0]  m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  m_tuser
);

    localparam int X_W = clog2_min1(IMG_WIDTH);
    localparam int Y_W = clog2_min1(IMG_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);
    localparam logic [X_W-1:0]        X_MAX     = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0]        Y_MAX     = Y_W'(IMG_HEIGHT - 1);

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_vld_p1;
    logic [X_W-1:0]        x_out;
    logic [Y_W-1:0]        y_out;
    logic                  done_q;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [1:0]            fifo_count;
    logic [BIT_WIDTH-1:0]  fifo_head;

    logic                  pop;
    logic                  issue;
    logic                  last_xfer;
    logic [2:0]            occ;
    logic [2:0]            occ_after_pop;

    // Reads in flight count towards occupancy so the buffer can never be oversubscribed
    assign pop           = m_tvalid & m_tready;
    assign occ           = {1'b0, fifo_count} + {2'b00, rd_vld_p1};
    assign occ_after_pop = occ - {2'b00, pop};
    assign issue         = (state_q == ST_READ) && (occ_after_pop < 3'd2);
    assign last_xfer     = pop && (x_out == X_MAX) && (y_out == Y_MAX);

    assign bram_ena   = issue;
    assign bram_wea   = 1'b0;
    assign bram_dina  = '0;
    assign bram_addra = rd_addr;

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign m_tvalid = ~fifo_empty;
    assign m_tdata  = m_tvalid ? fifo_head : '0;
    assign m_tlast  = m_tvalid && (x_out == X_MAX);
    assign m_tuser  = m_tvalid && (x_out == '0) && (y_out == '0);

    // State register
    always_ff @(posedge clka) begin
        if (rsta) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state: start only honoured in IDLE; DRAIN waits for the final handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_READ;
            ST_READ:  if (issue && (rd_addr == LAST_ADDR)) state_d = ST_DRAIN;
            ST_DRAIN: if (last_xfer) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Read address, in-flight flag, output raster counters and done pulse
    always_ff @(posedge clka) begin
        if (rsta) begin
            rd_addr   <= '0;
            rd_vld_p1 <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            done_q    <= 1'b0;
        end else begin
            rd_vld_p1 <= issue;
            done_q    <= last_xfer;
            if (last_xfer)  rd_addr <= '0;
            else if (issue) rd_addr <= rd_addr + ADDR_WIDTH'(1);
            if (pop) begin
                if (x_out == X_MAX) begin
                    x_out <= '0;
                    y_out <= (y_out == Y_MAX) ? '0 : y_out + Y_W'(1);
                end else begin
                    x_out <= x_out + X_W'(1);
                end
            end
        end
    end

    // ---- stage p1: BRAM data returns one cycle after issue and is captured here ----
    pix_fifo2 #(
        .BIT_WIDTH(BIT_WIDTH)
    ) u_fifo (
        .clk   (clka),
        .rst   (rsta),
        .push  (rd_vld_p1),
        .din   (bram_douta),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    a_occ_bound:   assert property (@(posedge clka) disable iff (rsta) occ <= 3'd2);
    a_no_overfill: assert property (@(posedge clka) disable iff (rsta) !(fifo_full && rd_vld_p1 && !pop));

endmodule

// File: tb/tb_bram_frame_reader.sv
// Scoreboard bench for bram_frame_reader on a 4x3 frame with a mem[a]=a[7:0] BRAM model.
module tb_bram_frame_reader;

    localparam int AW = 18;
    localparam int BW = 8;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;

    logic          clka = 1'b0;
    logic          rsta = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, bram_ena, bram_wea;
    logic [AW-1:0] bram_addra;
    logic [BW-1:0] bram_dina;
    logic [BW-1:0] bram_douta = '0;
    logic [BW-1:0] m_tdata;
    logic          m_tvalid, m_tlast, m_tuser;
    logic          m_tready = 1'b0;

    bram_frame_reader #(
        .ADDR_WIDTH(AW), .BIT_WIDTH(BW), .IMG_WIDTH(W), .IMG_HEIGHT(H)
    ) dut (
        .clka(clka), .rsta(rsta), .start(start), .busy(busy), .done(done),
        .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra),
        .bram_dina(bram_dina), .bram_douta(bram_douta),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .m_tuser(m_tuser)
    );

    always #5 clka = ~clka;

    // BRAM model: one-cycle read latency, contents mem[a] = a[7:0]
    always @(posedge clka) begin
        if (bram_ena) bram_douta <= bram_addra[7:0];
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [9:0]  exp_q[$];
    int          cyc = 0;
    int          frame_xfers, frame_ena, first_cyc, last_cyc, done_cnt, done_cyc;
    int          occ = 0;
    logic [AW-1:0] exp_addr;
    logic        prev_stall = 1'b0;
    logic [10:0] prev_word = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Output monitor: pops the scoreboard on every handshake and tracks per-frame events
    always @(negedge clka) begin
        logic [9:0] e;
        cyc++;
        if (prev_stall)
            check_val("stall_stable", {21'd0, m_tvalid, m_tdata, m_tlast, m_tuser}, {21'd0, prev_word});
        if (bram_ena) begin
            frame_ena++;
            occ++;
            check_val("bram_addr", 32'(bram_addra), 32'(exp_addr));
            exp_addr = exp_addr + 1'b1;
        end
        if (m_tvalid && m_tready) begin
            occ--;
            if (exp_q.size() == 0) begin
                check_val("extra_pixel", 32'(m_tdata), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_val("pixel", {22'd0, m_tdata, m_tlast, m_tuser}, {22'd0, e});
            end
            if (frame_xfers == 0) first_cyc = cyc;
            last_cyc = cyc;
            frame_xfers++;
        end
        if (bram_ena) check_val("occupancy_le2", 32'(occ <= 2), 32'd1);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rsta) occ = 0;
        prev_stall = m_tvalid && !m_tready && !rsta;
        prev_word  = {m_tvalid, m_tdata, m_tlast, m_tuser};
    end

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic sample();
        @(negedge clka);
        #1;
    endtask

    // Queue the expected frame and clear per-frame bookkeeping
    task automatic arm_frame();
        for (int i = 0; i < N; i++)
            exp_q.push_back({i[7:0], (i % W) == (W - 1), i == 0});
        frame_xfers = 0;
        frame_ena   = 0;
        first_cyc   = -1;
        last_cyc    = -1;
        done_cnt    = 0;
        done_cyc    = -1;
        exp_addr    = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input bit rand_ready);
        bit seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (rand_ready) m_tready = 1'($urandom_range(0, 1));
            sample();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check_val("done_seen", 32'(seen), 32'd1);
        m_tready = 1'b1;
    endtask

    task automatic check_frame_end(input string tag, input bit no_gaps);
        check_val({tag, "_xfers"}, 32'(frame_xfers), N);
        check_val({tag, "_reads"}, 32'(frame_ena), N);
        check_val({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check_val({tag, "_done_after_last"}, 32'(done_cyc), 32'(last_cyc + 1));
        check_val({tag, "_busy_low_with_done"}, 32'(busy), 32'd0);
        if (no_gaps) check_val({tag, "_no_gaps"}, 32'(last_cyc - first_cyc), N - 1);
    endtask

    initial begin
        // Reset, then ten idle cycles with everything quiet
        repeat (3) step();
        rsta = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sample();
            check_val("idle_quiet", {28'd0, bram_ena, m_tvalid, busy, done}, 32'd0);
        end
        check_val("idle_outputs", {20'd0, m_tdata, m_tlast, m_tuser, bram_wea, 1'b0}, 32'd0);
        check_val("idle_addr_dina", {6'd0, bram_addra, bram_dina}, 32'd0);

        // Full-rate frame: latency and back-to-back stream
        step();
        m_tready = 1'b1;
        arm_frame();
        start = 1'b1;
        sample();
        check_val("pre_start_busy", 32'(busy), 32'd0);
        step();
        start = 1'b0;
        sample();
        check_val("t1_read_issued", {29'd0, bram_ena, m_tvalid, busy}, 32'b101);
        sample();
        check_val("t2_not_valid", 32'(m_tvalid), 32'd0);
        sample();
        check_val("t3_valid_sof", {22'd0, m_tvalid, m_tuser, m_tdata}, {22'd0, 1'b1, 1'b1, 8'h00});
        wait_done(1'b0);
        check_frame_end("full_rate", 1'b1);

        // Random backpressure
        step();
        arm_frame();
        pulse_start();
        wait_done(1'b1);
        check_frame_end("rand_ready", 1'b0);

        // Long stall from T+2, then release
        step();
        m_tready = 1'b0;
        arm_frame();
        pulse_start();
        for (int i = 0; i < 21; i++) sample();
        check_val("stall_two_reads", 32'(frame_ena), 32'd2);
        check_val("stall_head", {23'd0, m_tvalid, m_tdata}, {23'd0, 1'b1, 8'h00});
        step();
        m_tready = 1'b1;
        wait_done(1'b0);
        check_frame_end("stall_release", 1'b1);

        // Second start mid-frame is ignored
        step();
        arm_frame();
        pulse_start();
        repeat (4) step();
        pulse_start();
        wait_done(1'b0);
        for (int i = 0; i < 10; i++) sample();
        check_val("restart_single_done", 32'(done_cnt), 32'd1);
        check_frame_end("restart_ignored", 1'b1);
        check_val("restart_idle_after", {30'd0, busy, m_tvalid}, 32'd0);

        // Reset after the fifth transfer aborts the frame
        step();
        arm_frame();
        pulse_start();
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 100; i++) begin
                sample();
                if (frame_xfers >= 5) begin
                    hit = 1'b1;
                    break;
                end
            end
            check_val("reached_5th_pixel", 32'(hit), 32'd1);
        end
        step();
        rsta = 1'b1;
        step();
        rsta = 1'b0;
        sample();
        check_val("post_reset_ctl", {28'd0, busy, done, bram_ena, m_tvalid}, 32'd0);
        check_val("post_reset_data", {6'd0, bram_addra, m_tdata}, 32'd0);
        check_val("post_reset_side", {30'd0, m_tlast, m_tuser}, 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 5; i++) sample();
        check_val("abort_no_done", 32'(done_cnt), 32'd0);
        exp_q.delete();
        step();
        arm_frame();
        pulse_start();
        wait_done(1'b0);
        check_frame_end("fresh_frame", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
